// File: rtl/droop_corr_combiner_if.sv
// rtl/droop_corr_combiner_if.sv - sample/correction/status bundle of the droop correction combiner
interface droop_corr_combiner_if;
   logic               trig;
   logic signed [12:0] din;
   logic signed [15:0] iir_in;
   logic               bypass;
   logic               flush;
   logic               satClr;
   logic signed [12:0] dout;
   logic               valid;
   logic               satDetect;
   logic [7:0]         satCount;

   // master drives samples and controls, slave is the combiner
   modport master (
      output trig, din, iir_in, bypass, flush, satClr,
      input  dout, valid, satDetect, satCount
   );

   modport slave (
      input  trig, din, iir_in, bypass, flush, satClr,
      output dout, valid, satDetect, satCount
   );
endinterface

// File: rtl/droop_corr_combiner.sv
// rtl/droop_corr_combiner.sv - delay-aligned droop correction add with 13-bit saturation and status
module droop_corr_combiner #(
   parameter int DELAY      = 2,
   parameter int CORR_SHIFT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   droop_corr_combiner_if.slave bus
);
   localparam int                FW       = $clog2(DELAY + 1);
   localparam logic [FW-1:0]     FILL_MAX = FW'(DELAY);
   localparam logic signed [16:0] SUM_HI  = 17'sd4095;
   localparam logic signed [16:0] SUM_LO  = -17'sd4096;

   logic               r_trig_a;
   logic               r_trig_b;
   logic               w_edge;
   logic               w_take;
   logic signed [12:0] r_dly [DELAY];
   logic [FW-1:0]      r_fill;
   logic signed [12:0] r_raw;
   logic signed [15:0] r_corr;
   logic signed [15:0] w_corr;
   logic               r_s1_v;
   logic               r_s2_v;
   logic signed [16:0] r_sum;
   logic signed [12:0] w_clamp;
   logic               w_sat;
   logic               w_out;
   logic signed [12:0] r_dout;
   logic               r_valid;
   logic               r_sat_det;
   logic [7:0]         r_sat_cnt;

   // one strobe per trig rising transition; a flush in the same cycle swallows it
   assign w_edge = r_trig_a & ~r_trig_b;
   assign w_take = w_edge & ~bus.flush;
   assign w_corr = bus.bypass ? 16'sd0 : ($signed(bus.iir_in) >>> CORR_SHIFT);
   // a result that reaches stage 3 during a flush is dropped
   assign w_out  = r_s2_v & ~bus.flush;

   // trig synchroniser / edge detector flops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_trig_a <= 1'b0;
         r_trig_b <= 1'b0;
      end else begin
         r_trig_a <= bus.trig;
         r_trig_b <= r_trig_a;
      end
   end

   // sample-indexed delay line, advanced once per accepted edge
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         for (int i = 0; i < DELAY; i++) r_dly[i] <= '0;
      end else if (w_take) begin
         r_dly[0] <= bus.din;
         for (int i = 1; i < DELAY; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   // stage 1: capture aligned raw sample and scaled correction, track fill
   always_ff @(posedge clk) begin
      if (rst) begin
         r_raw  <= '0;
         r_corr <= '0;
         r_fill <= '0;
         r_s1_v <= 1'b0;
      end else if (bus.flush) begin
         r_fill <= '0;
         r_s1_v <= 1'b0;
      end else begin
         r_s1_v <= w_take && (r_fill == FILL_MAX);
         if (w_take) begin
            r_raw  <= r_dly[DELAY-1];
            r_corr <= w_corr;
            if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
         end
      end
   end

   // stage 2: widened sum, recomputed every cycle from the held stage-1 operands
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_s2_v <= 1'b0;
      end else begin
         r_sum  <= {{4{r_raw[12]}}, r_raw} + {r_corr[15], r_corr};
         r_s2_v <= bus.flush ? 1'b0 : r_s1_v;
      end
   end

   // clamp the 17-bit sum back into the 13-bit sample range
   always_comb begin
      w_sat   = 1'b0;
      w_clamp = r_sum[12:0];
      if (r_sum > SUM_HI) begin
         w_sat   = 1'b1;
         w_clamp = 13'h0FFF;
      end else if (r_sum < SUM_LO) begin
         w_sat   = 1'b1;
         w_clamp = 13'h1000;
      end
   end

   // stage 3: publish the result; dout only moves with a valid strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= w_out;
         if (w_out) r_dout <= w_clamp;
      end
   end

   // sticky saturation flag and saturating event counter; clear beats a same-cycle event
   always_ff @(posedge clk) begin
      if (rst || bus.satClr) begin
         r_sat_det <= 1'b0;
         r_sat_cnt <= '0;
      end else if (w_out && w_sat) begin
         r_sat_det <= 1'b1;
         if (r_sat_cnt != 8'hFF) r_sat_cnt <= r_sat_cnt + 8'd1;
      end
   end

   assign bus.dout      = r_dout;
   assign bus.valid     = r_valid;
   assign bus.satDetect = r_sat_det;
   assign bus.satCount  = r_sat_cnt;
endmodule

// File: tb/tb_droop_corr_combiner.sv
// tb/tb_droop_corr_combiner.sv - self-checking bench for droop_corr_combiner
module tb_droop_corr_combiner;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               trig = 1'b0;
   logic               bypass = 1'b0;
   logic               flush = 1'b0;
   logic               sat_clr = 1'b0;
   logic signed [12:0] din = '0;
   logic signed [15:0] iir = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   droop_corr_combiner_if ifa ();
   droop_corr_combiner_if ifb ();

   assign ifa.trig = trig;   assign ifb.trig = trig;
   assign ifa.din = din;     assign ifb.din = din;
   assign ifa.iir_in = iir;  assign ifb.iir_in = iir;
   assign ifa.bypass = bypass; assign ifb.bypass = bypass;
   assign ifa.flush = flush; assign ifb.flush = flush;
   assign ifa.satClr = sat_clr; assign ifb.satClr = sat_clr;

   droop_corr_combiner #(.DELAY(2), .CORR_SHIFT(0)) u_a (.clk(clk), .rst(rst), .bus(ifa));
   droop_corr_combiner #(.DELAY(1), .CORR_SHIFT(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int dly_of(input int d);
      return (d == 0) ? 2 : 1;
   endfunction

   function automatic int sh_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   // reference model: sample history since last flush, expected outputs keyed by due clock
   int  t = 0;
   bit  prev_trig, pend;
   int  hist[$];
   int  exp_val[int];
   bit  exp_sat[int];
   bit  exp_now[2];
   int  exp_dout[2];
   bit  exp_det[2];
   int  exp_cnt[2];

   always @(posedge clk) begin
      int raw, corr, sum, key;
      bit s;
      t = t + 1;
      if (rst) begin
         prev_trig = 0; pend = 0;
         hist.delete(); exp_val.delete(); exp_sat.delete();
         for (int d = 0; d < 2; d++) begin
            exp_now[d] = 0; exp_dout[d] = 0; exp_det[d] = 0; exp_cnt[d] = 0;
         end
      end else begin
         if (flush) begin
            hist.delete();
            for (int d = 0; d < 2; d++)
               for (int j = 0; j < 4; j++) begin
                  key = (t + j) * 2 + d;
                  if (exp_val.exists(key)) begin exp_val.delete(key); exp_sat.delete(key); end
               end
         end else if (pend) begin
            hist.push_back(int'(din));
            if (hist.size() > 9) void'(hist.pop_front());
            for (int d = 0; d < 2; d++) begin
               if (hist.size() > dly_of(d)) begin
                  raw  = hist[hist.size() - 1 - dly_of(d)];
                  corr = bypass ? 0 : (int'(iir) >>> sh_of(d));
                  sum  = raw + corr;
                  s    = (sum > 4095) || (sum < -4096);
                  if (sum > 4095) sum = 4095;
                  if (sum < -4096) sum = -4096;
                  exp_val[(t + 2) * 2 + d] = sum;
                  exp_sat[(t + 2) * 2 + d] = s;
               end
            end
         end
         pend = trig && !prev_trig;
         prev_trig = trig;
         for (int d = 0; d < 2; d++) begin
            key = t * 2 + d;
            exp_now[d] = exp_val.exists(key);
            s = 0;
            if (exp_now[d]) begin
               exp_dout[d] = exp_val[key];
               s = exp_sat[key];
               exp_val.delete(key); exp_sat.delete(key);
            end
            if (sat_clr) begin
               exp_det[d] = 0; exp_cnt[d] = 0;
            end else if (s) begin
               exp_det[d] = 1;
               if (exp_cnt[d] < 255) exp_cnt[d]++;
            end
         end
      end
   end

   // per-cycle comparison against the model, plus valid-pulse counters for directed checks
   int va_cnt = 0, vb_cnt = 0;
   always @(negedge clk) begin
      if (t > 0) begin
         check("a.valid", int'(ifa.valid), int'(exp_now[0]));
         check("a.dout", int'(ifa.dout), exp_dout[0]);
         check("a.satDetect", int'(ifa.satDetect), int'(exp_det[0]));
         check("a.satCount", int'(ifa.satCount), exp_cnt[0]);
         check("b.valid", int'(ifb.valid), int'(exp_now[1]));
         check("b.dout", int'(ifb.dout), exp_dout[1]);
         check("b.satDetect", int'(ifb.satDetect), int'(exp_det[1]));
         check("b.satCount", int'(ifb.satCount), exp_cnt[1]);
         if (ifa.valid) va_cnt++;
         if (ifb.valid) vb_cnt++;
      end
   end

   typedef struct {
      int din; int iir; bit byp;
      bit va; int da; int ca;
      bit vb; int db; int cb;
   } vec_t;
   vec_t tbl[9];

   // one trigger with trig high 2 clocks; samples outputs 3 clocks after trig is first sampled
   task automatic slow_send(input vec_t v, input bit chk, input bit clr_at_out);
      din = 13'(v.din); iir = 16'(v.iir); bypass = v.byp; trig = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; trig = 1'b0;
      @(posedge clk); #1; sat_clr = clr_at_out;
      @(posedge clk);
      @(negedge clk); sat_clr = 1'b0;
      if (chk) begin
         check("tbl.a.valid", int'(ifa.valid), int'(v.va));
         if (v.va) check("tbl.a.dout", int'(ifa.dout), v.da);
         check("tbl.a.satCount", int'(ifa.satCount), v.ca);
         check("tbl.b.valid", int'(ifb.valid), int'(v.vb));
         if (v.vb) check("tbl.b.dout", int'(ifb.dout), v.db);
         check("tbl.b.satCount", int'(ifb.satCount), v.cb);
      end
      @(posedge clk); #1;
   endtask

   // minimum-spacing trigger: high one clock, low one clock
   task automatic fast_send(input int dv, input int iv, input bit b);
      din = 13'(dv); iir = 16'(iv); bypass = b; trig = 1'b1;
      @(posedge clk); #1; trig = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{10,    0,    1'b1, 1'b0, 0,     0, 1'b0, 0,     0};
      tbl[1] = '{20,    0,    1'b1, 1'b0, 0,     0, 1'b1, 10,    0};
      tbl[2] = '{30,    0,    1'b1, 1'b1, 10,    0, 1'b1, 20,    0};
      tbl[3] = '{40,    0,    1'b1, 1'b1, 20,    0, 1'b1, 30,    0};
      tbl[4] = '{1000,  -400, 1'b0, 1'b1, -370,  0, 1'b1, -60,   0};
      tbl[5] = '{4000,  -400, 1'b0, 1'b1, -360,  0, 1'b1, 900,   0};
      tbl[6] = '{-4000, 500,  1'b0, 1'b1, 1500,  0, 1'b1, 4095,  1};
      tbl[7] = '{0,     500,  1'b0, 1'b1, 4095,  1, 1'b1, -3875, 1};
      tbl[8] = '{0,     -500, 1'b0, 1'b1, -4096, 2, 1'b1, -125,  1};

      // reset held while trig toggles
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         trig = ~trig;
         @(negedge clk);
         check("rst.dout", int'(ifa.dout), 0);
         check("rst.valid", int'(ifa.valid), 0);
         check("rst.satDetect", int'(ifa.satDetect), 0);
         check("rst.satCount", int'(ifa.satCount), 0);
         @(posedge clk); #1;
      end
      rst = 1'b0; trig = 1'b0;
      va_cnt = 0; vb_cnt = 0;
      fast_send(1, 0, 1'b1);
      fast_send(2, 0, 1'b1);
      idle(4);
      check("rst.fill.a", va_cnt, 0);
      check("rst.fill.b", vb_cnt, 1);

      // clean start for the vector table
      flush = 1'b1; sat_clr = 1'b1;
      idle(1);
      flush = 1'b0; sat_clr = 1'b0;
      for (int i = 0; i < 9; i++) slow_send(tbl[i], 1'b1, 1'b0);

      // satClr on the same edge as a saturating result
      v = '{4000, 500, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0};
      slow_send(v, 1'b0, 1'b0);
      slow_send(v, 1'b0, 1'b0);
      slow_send(v, 1'b0, 1'b1);
      check("clr.a.satDetect", int'(ifa.satDetect), 0);
      check("clr.a.satCount", int'(ifa.satCount), 0);
      check("clr.b.satCount", int'(ifb.satCount), 0);

      // flush with a result in flight, then refill
      va_cnt = 0; vb_cnt = 0;
      din = 13'(111); iir = '0; bypass = 1'b1; trig = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; trig = 1'b0; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      idle(4);
      check("flush.drop.a", va_cnt, 0);
      check("flush.drop.b", vb_cnt, 0);
      fast_send(222, 0, 1'b1);
      fast_send(333, 0, 1'b1);
      idle(4);
      check("flush.refill.a", va_cnt, 0);
      check("flush.refill.b", vb_cnt, 1);
      check("flush.refill.b.dout", int'(ifb.dout), 222);
      fast_send(444, 0, 1'b1);
      idle(4);
      check("flush.first.a", va_cnt, 1);
      check("flush.first.a.dout", int'(ifa.dout), 222);
      check("flush.first.b.dout", int'(ifb.dout), 333);

      // trig held high for 10 clocks
      va_cnt = 0; vb_cnt = 0;
      din = 13'(555); bypass = 1'b1; trig = 1'b1;
      idle(10);
      trig = 1'b0;
      idle(5);
      check("held.a.valids", va_cnt, 1);
      check("held.b.valids", vb_cnt, 1);
      check("held.a.dout", int'(ifa.dout), 333);
      fast_send(666, 0, 1'b1);
      idle(4);
      check("held.single.a.dout", int'(ifa.dout), 444);
      check("held.single.b.dout", int'(ifb.dout), 555);

      // 300 saturating samples: counter must hold at 255
      sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
      for (int i = 0; i < 300; i++) fast_send(4000, 500, 1'b0);
      idle(5);
      check("satcnt.a.hold", int'(ifa.satCount), 255);
      check("satcnt.b.hold", int'(ifb.satCount), 255);
      check("satcnt.a.det", int'(ifa.satDetect), 1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         flush   = ($urandom_range(0, 24) == 0);
         sat_clr = ($urandom_range(0, 15) == 0);
         fast_send($signed(13'($urandom)), $signed(16'($urandom)), ($urandom_range(0, 3) == 0));
         flush = 1'b0; sat_clr = 1'b0;
         idle($urandom_range(0, 2));
      end
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/droop_corr_combiner.md
# droop_corr_combiner

Downstream companion to the anti-droop IIR accumulator. Takes the raw 13-bit signed sample stream and the 16-bit IIR correction word, aligns each raw sample with its correction by a programmable sample-indexed delay, adds them, saturates the result back to 13 bits, and emits a corrected sample with a one-cycle valid strobe. It also keeps a sticky saturation flag and a saturating event counter for status readback.

## Interface

Parameters:
- `DELAY`, 2: raw-sample delay in trigger events (sample-indexed, not clock-indexed). Legal range is 1..8.
- `CORR_SHIFT`, 0: arithmetic right shift applied to the correction word before the add. Legal range is 0..15.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `trig` in 1: sample strobe, same signal that feeds the IIR stage. A rising edge marks a new sample.
- `din` in 13 signed: raw sample, same bus that feeds the IIR stage.
- `iir_in` in 16 signed: correction word from the IIR stage output.
- `bypass` in 1: when 1, the correction term is forced to 0.
- `flush` in 1: clears the delay line and fill state. Asserted together with the IIR accumulator clear.
- `satClr` in 1: clears `satDetect` and `satCount`.
- `dout` out 13 signed, reg: corrected sample.
- `valid` out 1, reg: one-cycle strobe marking a new `dout`.
- `satDetect` out 1, reg: sticky flag, set when a result saturates.
- `satCount` out 8, reg: number of saturated outputs. Holds at 255 and does not wrap.

## Operation

- **Trigger edge detect.** `trig` passes through two flops, `trig_a` then `trig_b`. The internal strobe is `edge = trig_a & ~trig_b`. There is exactly one edge per `trig` rising transition, however long `trig` stays high.
- **Stage 1 (on `edge`):**
  - Shift `din` into a DELAY-deep delay line.
  - Capture the delay-line tail, i.e. the sample from DELAY edges ago, into `raw_r`. With DELAY=1 this is the sample captured on the previous edge.
  - Capture `corr_r = bypass ? 0 : (iir_in >>> CORR_SHIFT)`.
  - Increment the fill counter, saturating at DELAY.
  - Set `s1_v` when the fill counter already equalled DELAY before this edge.
- **Stage 2 (unconditional, one cycle after stage 1):**
  - `sum_r` (17-bit signed) = sign-extended `raw_r` + sign-extended `corr_r`.
  - `s2_v` <= `s1_v`, and `s1_v` clears after a single cycle.
- **Stage 3, saturate:**
  - Clamp `sum_r` to the range -4096..4095 and register it into `dout`.
  - `valid` <= `s2_v`.
  - If `s2_v` is high and the clamp was active, set `satDetect` and increment `satCount`, saturating at 255.
- **Fill gating.** The first DELAY edges after `rst` or `flush` produce no `valid`. Every later edge produces exactly one `valid`.
- **`flush`:**
  - Zeroes the delay line, the fill counter, `s1_v` and `s2_v`. Any result already in flight is dropped.
  - Leaves `dout`, `satDetect` and `satCount` unchanged.
  - An `edge` in the same cycle as `flush` is ignored.
- **`satClr`:** clears `satDetect` and `satCount`. If a saturation event occurs in the same cycle, the clear wins and the event is not counted.
- **`rst`:** every register goes to 0, including `trig_a` and `trig_b`, so `valid=0` and `dout=0`. `rst` has priority over `flush` and `satClr`.

## Timing

- `trig` first sampled high at edge k:
  - `trig_a=1` after k, so `edge` is high during cycle k+1.
  - Stage 1 captures at edge k+1.
  - `sum_r` updates at k+2.
  - `dout` and `valid` update at k+3.
- Latency from the first sampled-high `trig` to `valid` is 3 clocks.
- `iir_in` is sampled at edge k+1, the same edge at which the IIR stage launches its own update. The correction applied is therefore the IIR value from before this sample.
- Back-to-back triggers are supported at any spacing of 2 clocks or more, which is the minimum for a high-low-high `trig`. The pipeline has no stalls.
- `valid` is never high for two consecutive cycles.
- `dout` holds its value between strobes.

## Test plan

- **Reset.** Assert `rst` for 2 cycles while toggling `trig`. Required: `dout=0`, `valid=0`, `satDetect=0`, `satCount=0` throughout, and no `valid` for the first 2 edges after release.
- **Alignment.** DELAY=2, `bypass=1`, samples 10, 20, 30, 40 on successive edges. Required: outputs are 10 then 20, each with `valid` 3 clocks after `trig` is sampled high, and nothing is output for the first two edges.
- **Correction add.** DELAY=1, CORR_SHIFT=2, `iir_in=-400`, raw sample 1000. Required: `dout=900`.
- **Saturation.**
  - Raw 4000 with `iir_in=+500`: required `dout=4095`, `satDetect=1`, `satCount=1`.
  - Raw -4000 with `iir_in=-500`: required `dout=-4096`, `satCount=2`.
  - 300 saturating samples in total: required `satCount` holds at 255.
- **Simultaneous events.**
  - `satClr` in the same cycle as a saturating stage-3 result: required `satDetect=0`, `satCount=0`.
  - `flush` with one result in flight: required no `valid` for that result, and the next valid output appears only after DELAY fresh edges.
- **Held trigger.** `trig` held high for 10 cycles. Required: exactly one stage-1 capture and at most one `valid`.
